// File: rtl/snake_game_ctrl.sv
// Snake game sequencer for a 15x15 field. Owns the body ring buffer, the occupancy
// bitmap, movement, collision, growth and LFSR-driven apple placement.
module snake_game_ctrl #(
  parameter int         MAX_LEN   = 32,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic         mastClk,
  input  logic         rst,
  input  logic         start,
  input  logic         step,
  input  logic         up,
  input  logic         down,
  input  logic         left,
  input  logic         right,
  output logic [3:0]   Head_X,
  output logic [3:0]   Head_Y,
  output logic [3:0]   Tail_X,
  output logic [3:0]   Tail_Y,
  output logic [3:0]   Apple_X,
  output logic [3:0]   Apple_Y,
  output logic [224:0] Cell_Snake_Vector,
  output logic [7:0]   score,
  output logic         game_over,
  output logic         won
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_LEN - 1);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_APPLE = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  // Opposite directions differ only in bit 0, which makes reversal detection an xor.
  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  logic [1:0]       state, dir, next_dir, req_dir;
  logic             step_pend;
  logic [7:0]       lfsr, length;
  logic [7:0]       ring [MAX_LEN];
  logic [PTR_W-1:0] head_ptr, tail_ptr, hp_nx, tp_nx;
  logic [3:0]       nh_x, nh_y, cand_x, cand_y;
  logic             wall, eat, at_tail, self_hit, do_move, cand_ok, req_valid, req_ok;
  logic [7:0]       nh_idx, tail_idx, cand_idx, len_inc, score_inc;
  logic [255:0]     occ;

  function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
    return ({4'd0, x} * 8'd15) + {4'd0, y};
  endfunction

  always_comb begin
    hp_nx = (head_ptr == LAST_PTR) ? '0 : head_ptr + PTR_W'(1);
    tp_nx = (tail_ptr == LAST_PTR) ? '0 : tail_ptr + PTR_W'(1);
    occ   = {31'd0, Cell_Snake_Vector};

    nh_x = Head_X;
    nh_y = Head_Y;
    wall = 1'b0;
    case (next_dir)
      D_UP:    if (Head_Y == 4'd0)  wall = 1'b1; else nh_y = Head_Y - 4'd1;
      D_DOWN:  if (Head_Y == 4'd14) wall = 1'b1; else nh_y = Head_Y + 4'd1;
      D_LEFT:  if (Head_X == 4'd0)  wall = 1'b1; else nh_x = Head_X - 4'd1;
      default: if (Head_X == 4'd14) wall = 1'b1; else nh_x = Head_X + 4'd1;
    endcase
    nh_idx   = cell_idx(nh_x, nh_y);
    tail_idx = cell_idx(Tail_X, Tail_Y);
    eat      = (nh_x == Apple_X) && (nh_y == Apple_Y);
    at_tail  = (nh_x == Tail_X) && (nh_y == Tail_Y);
    // Stepping onto the tail is legal unless eating, because the tail vacates this move.
    self_hit = occ[nh_idx] && !(at_tail && !eat);
    do_move  = (state == S_RUN) && (step || step_pend);

    cand_x   = lfsr[3:0];
    cand_y   = lfsr[7:4];
    cand_idx = cell_idx(cand_x, cand_y);
    cand_ok  = (cand_x < 4'd15) && (cand_y < 4'd15) && !occ[cand_idx];

    len_inc   = length + 8'd1;
    score_inc = (score == 8'hFF) ? score : score + 8'd1;

    req_valid = up || down || left || right;
    if (up)        req_dir = D_UP;
    else if (down) req_dir = D_DOWN;
    else if (left) req_dir = D_LEFT;
    else           req_dir = D_RIGHT;
    req_ok = req_valid && (req_dir != (dir ^ 2'b01));
  end

  always_ff @(posedge mastClk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge mastClk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      dir       <= D_RIGHT;
      next_dir  <= D_RIGHT;
      step_pend <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) ring[i] <= 8'd0;
      ring[0]   <= {4'd5, 4'd7};
      ring[1]   <= {4'd6, 4'd7};
      ring[2]   <= {4'd7, 4'd7};
      tail_ptr  <= '0;
      head_ptr  <= PTR_W'(2);
      length    <= 8'd3;
      Head_X    <= 4'd7;  Head_Y  <= 4'd7;
      Tail_X    <= 4'd5;  Tail_Y  <= 4'd7;
      Apple_X   <= 4'd11; Apple_Y <= 4'd7;
      Cell_Snake_Vector <= '0;
      Cell_Snake_Vector[82]  <= 1'b1;
      Cell_Snake_Vector[97]  <= 1'b1;
      Cell_Snake_Vector[112] <= 1'b1;
      score     <= 8'd0;
      game_over <= 1'b0;
      won       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_RUN;
        S_RUN: begin
          if (req_ok) next_dir <= req_dir;
          if (do_move) begin
            step_pend <= 1'b0;
            if (wall || self_hit) begin
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              dir            <= next_dir;
              head_ptr       <= hp_nx;
              ring[hp_nx]    <= {nh_x, nh_y};
              Head_X         <= nh_x;
              Head_Y         <= nh_y;
              if (eat) begin
                Cell_Snake_Vector[nh_idx] <= 1'b1;
                length <= len_inc;
                score  <= score_inc;
                if (len_inc == MAX_LEN8) begin
                  won       <= 1'b1;
                  game_over <= 1'b1;
                  state     <= S_OVER;
                end else begin
                  state <= S_APPLE;
                end
              end else begin
                // Later assignment wins, so re-entering the old tail cell keeps it set.
                Cell_Snake_Vector[tail_idx] <= 1'b0;
                Cell_Snake_Vector[nh_idx]   <= 1'b1;
                tail_ptr <= tp_nx;
                {Tail_X, Tail_Y} <= ring[tp_nx];
              end
            end
          end
        end
        S_APPLE: begin
          if (req_ok) next_dir <= req_dir;
          if (step) step_pend <= 1'b1;
          if (cand_ok) begin
            Apple_X <= cand_x;
            Apple_Y <= cand_y;
            state   <= S_RUN;
          end
        end
        default: begin
          if (start) begin
            state     <= S_RUN;
            dir       <= D_RIGHT;
            next_dir  <= D_RIGHT;
            step_pend <= 1'b0;
            ring[0]   <= {4'd5, 4'd7};
            ring[1]   <= {4'd6, 4'd7};
            ring[2]   <= {4'd7, 4'd7};
            tail_ptr  <= '0;
            head_ptr  <= PTR_W'(2);
            length    <= 8'd3;
            Head_X    <= 4'd7;  Head_Y  <= 4'd7;
            Tail_X    <= 4'd5;  Tail_Y  <= 4'd7;
            Apple_X   <= 4'd11; Apple_Y <= 4'd7;
            Cell_Snake_Vector <= '0;
            Cell_Snake_Vector[82]  <= 1'b1;
            Cell_Snake_Vector[97]  <= 1'b1;
            Cell_Snake_Vector[112] <= 1'b1;
            score     <= 8'd0;
            game_over <= 1'b0;
            won       <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: init layout, stepping, eating, direction
// rules, wall death and restart, tail chase and reset during apple search.
module tb_snake_game_ctrl;

  logic         mastClk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, step = 1'b0;
  logic         up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [3:0]   Head_X, Head_Y, Tail_X, Tail_Y, Apple_X, Apple_Y;
  logic [224:0] Cell_Snake_Vector;
  logic [7:0]   score;
  logic         game_over, won;

  int vectors = 0;
  int miscompares = 0;
  logic [224:0] init_vec;
  logic [224:0] exp_vec;

  snake_game_ctrl #(.MAX_LEN(32), .LFSR_SEED(8'hA5)) dut (
    .mastClk(mastClk), .rst(rst), .start(start), .step(step),
    .up(up), .down(down), .left(left), .right(right),
    .Head_X(Head_X), .Head_Y(Head_Y), .Tail_X(Tail_X), .Tail_Y(Tail_Y),
    .Apple_X(Apple_X), .Apple_Y(Apple_Y), .Cell_Snake_Vector(Cell_Snake_Vector),
    .score(score), .game_over(game_over), .won(won)
  );

  always #5 mastClk = ~mastClk;

  task pulse_step();
    @(negedge mastClk); step = 1'b1;
    @(negedge mastClk); step = 1'b0;
  endtask

  task pulse_start();
    @(negedge mastClk); start = 1'b1;
    @(negedge mastClk); start = 1'b0;
  endtask

  task pulse_dir(input logic u, input logic d, input logic l, input logic r);
    @(negedge mastClk); up = u; down = d; left = l; right = r;
    @(negedge mastClk); up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task do_reset();
    @(negedge mastClk); rst = 1'b0;
    @(negedge mastClk); rst = 1'b1;
  endtask

  task wait_apple_moved(input logic [3:0] ox, input logic [3:0] oy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge mastClk);
      if ({Apple_X, Apple_Y} !== {ox, oy}) ok = 1'b1;
    end
  endtask

  task test_reset();
    rst = 1'b0;
    #23;
    vectors++;
    if ({Head_X, Head_Y, Tail_X, Tail_Y} !== {4'd7, 4'd7, 4'd5, 4'd7}) begin
      miscompares++;
      $display("[TB] FAIL reset_head_tail: got H(%0d,%0d) T(%0d,%0d), want H(7,7) T(5,7)", Head_X, Head_Y, Tail_X, Tail_Y);
    end
    vectors++;
    if ({Apple_X, Apple_Y, score, game_over, won} !== {4'd11, 4'd7, 8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_apple_score: got A(%0d,%0d) score=%0d go=%0b won=%0b, want A(11,7) 0 0 0", Apple_X, Apple_Y, score, game_over, won);
    end
    vectors++;
    if (Cell_Snake_Vector !== init_vec) begin
      miscompares++;
      $display("[TB] FAIL reset_vector: got %h, want %h", Cell_Snake_Vector, init_vec);
    end
    @(negedge mastClk); rst = 1'b1;
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y} !== {4'd7, 4'd7}) begin
      miscompares++;
      $display("[TB] FAIL idle_ignores_step: got H(%0d,%0d), want H(7,7)", Head_X, Head_Y);
    end
  endtask

  task test_straight_steps();
    logic [3:0] eh [3];
    logic [3:0] et [3];
    eh[0] = 4'd8; eh[1] = 4'd9; eh[2] = 4'd10;
    et[0] = 4'd6; et[1] = 4'd7; et[2] = 4'd8;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      vectors++;
      if ({Head_X, Head_Y, Tail_X, Tail_Y} !== {eh[i], 4'd7, et[i], 4'd7}) begin
        miscompares++;
        $display("[TB] FAIL step%0d_pos: got H(%0d,%0d) T(%0d,%0d), want H(%0d,7) T(%0d,7)", i + 1, Head_X, Head_Y, Tail_X, Tail_Y, eh[i], et[i]);
      end
    end
    exp_vec = '0; exp_vec[127] = 1'b1; exp_vec[142] = 1'b1; exp_vec[157] = 1'b1;
    vectors++;
    if (Cell_Snake_Vector !== exp_vec) begin
      miscompares++;
      $display("[TB] FAIL step3_vector: got %h, want %h", Cell_Snake_Vector, exp_vec);
    end
  endtask

  task test_eat_apple();
    bit ok;
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y, Tail_X, Tail_Y, score, won} !== {4'd11, 4'd7, 4'd8, 4'd7, 8'd1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL eat_pos_score: got H(%0d,%0d) T(%0d,%0d) score=%0d won=%0b, want H(11,7) T(8,7) 1 0", Head_X, Head_Y, Tail_X, Tail_Y, score, won);
    end
    vectors++;
    if ({Apple_X, Apple_Y} !== {4'd11, 4'd7}) begin
      miscompares++;
      $display("[TB] FAIL apple_holds: got A(%0d,%0d), want A(11,7)", Apple_X, Apple_Y);
    end
    wait_apple_moved(4'd11, 4'd7, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL apple_search_timeout: got no placement in 300 cycles, want placement");
    end
    vectors++;
    if (Apple_X > 4'd14 || Apple_Y > 4'd14 || Cell_Snake_Vector[Apple_X * 15 + Apple_Y] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL apple_cell_free: got A(%0d,%0d), want in-field cell with bit 0", Apple_X, Apple_Y);
    end
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y} !== {4'd12, 4'd7}) begin
      miscompares++;
      $display("[TB] FAIL run_after_apple: got H(%0d,%0d), want H(12,7)", Head_X, Head_Y);
    end
  endtask

  task test_direction();
    do_reset();
    pulse_start();
    pulse_dir(1'b0, 1'b0, 1'b1, 1'b0);
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y, game_over} !== {4'd8, 4'd7, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reversal_dropped: got H(%0d,%0d) go=%0b, want H(8,7) go=0", Head_X, Head_Y, game_over);
    end
    pulse_dir(1'b1, 1'b0, 1'b0, 1'b1);
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y, Tail_X, Tail_Y} !== {4'd8, 4'd6, 4'd7, 4'd7}) begin
      miscompares++;
      $display("[TB] FAIL up_priority: got H(%0d,%0d) T(%0d,%0d), want H(8,6) T(7,7)", Head_X, Head_Y, Tail_X, Tail_Y);
    end
  endtask

  task test_wall();
    do_reset();
    pulse_start();
    pulse_dir(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) pulse_step();
    vectors++;
    if ({Head_X, Head_Y, game_over} !== {4'd7, 4'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL top_row: got H(%0d,%0d) go=%0b, want H(7,0) go=0", Head_X, Head_Y, game_over);
    end
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y, game_over} !== {4'd7, 4'd0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL wall_hit: got H(%0d,%0d) go=%0b, want H(7,0) go=1", Head_X, Head_Y, game_over);
    end
    pulse_dir(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y, Tail_X, Tail_Y, game_over} !== {4'd7, 4'd0, 4'd7, 4'd2, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL over_frozen: got H(%0d,%0d) T(%0d,%0d) go=%0b, want H(7,0) T(7,2) go=1", Head_X, Head_Y, Tail_X, Tail_Y, game_over);
    end
    pulse_start();
    vectors++;
    if ({Head_X, Head_Y, Tail_X, Tail_Y, score, game_over} !== {4'd7, 4'd7, 4'd5, 4'd7, 8'd0, 1'b0} || Cell_Snake_Vector !== init_vec) begin
      miscompares++;
      $display("[TB] FAIL restart_layout: got H(%0d,%0d) T(%0d,%0d) score=%0d go=%0b, want H(7,7) T(5,7) 0 0 and init bitmap", Head_X, Head_Y, Tail_X, Tail_Y, score, game_over);
    end
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y} !== {4'd8, 4'd7}) begin
      miscompares++;
      $display("[TB] FAIL restart_runs_right: got H(%0d,%0d), want H(8,7)", Head_X, Head_Y);
    end
  endtask

  task test_tail_chase();
    bit ok;
    bit flip;
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) pulse_step();
    wait_apple_moved(4'd11, 4'd7, ok);
    // Loop away from the apple so the chase never eats.
    flip = ({Apple_X, Apple_Y} == {4'd11, 4'd6}) || ({Apple_X, Apple_Y} == {4'd10, 4'd6});
    pulse_dir(1'b0, 1'b0, 1'b0, 1'b0);
    if (flip) pulse_dir(1'b0, 1'b1, 1'b0, 1'b0); else pulse_dir(1'b1, 1'b0, 1'b0, 1'b0);
    pulse_step();
    pulse_dir(1'b0, 1'b0, 1'b1, 1'b0);
    pulse_step();
    if (flip) pulse_dir(1'b1, 1'b0, 1'b0, 1'b0); else pulse_dir(1'b0, 1'b1, 1'b0, 1'b0);
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y, Tail_X, Tail_Y, game_over} !== {4'd10, 4'd7, 4'd11, 4'd7, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL tail_chase: got H(%0d,%0d) T(%0d,%0d) go=%0b, want H(10,7) T(11,7) go=0", Head_X, Head_Y, Tail_X, Tail_Y, game_over);
    end
    exp_vec = '0; exp_vec[157] = 1'b1; exp_vec[172] = 1'b1;
    if (flip) begin exp_vec[173] = 1'b1; exp_vec[158] = 1'b1; end
    else      begin exp_vec[171] = 1'b1; exp_vec[156] = 1'b1; end
    vectors++;
    if (Cell_Snake_Vector !== exp_vec) begin
      miscompares++;
      $display("[TB] FAIL tail_chase_vector: got %h, want %h", Cell_Snake_Vector, exp_vec);
    end
  endtask

  task test_reset_mid_apple();
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) pulse_step();
    rst = 1'b0;
    #1;
    vectors++;
    if ({Head_X, Head_Y, Tail_X, Tail_Y, Apple_X, Apple_Y, score, game_over} !== {4'd7, 4'd7, 4'd5, 4'd7, 4'd11, 4'd7, 8'd0, 1'b0} || Cell_Snake_Vector !== init_vec) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_apple: got H(%0d,%0d) T(%0d,%0d) A(%0d,%0d) score=%0d go=%0b, want init layout", Head_X, Head_Y, Tail_X, Tail_Y, Apple_X, Apple_Y, score, game_over);
    end
    @(negedge mastClk); rst = 1'b1;
    pulse_step();
    vectors++;
    if ({Head_X, Head_Y} !== {4'd7, 4'd7}) begin
      miscompares++;
      $display("[TB] FAIL reset_to_idle: got H(%0d,%0d), want H(7,7)", Head_X, Head_Y);
    end
  endtask

  initial begin
    init_vec = '0; init_vec[82] = 1'b1; init_vec[97] = 1'b1; init_vec[112] = 1'b1;
    test_reset();
    test_straight_steps();
    test_eat_apple();
    test_direction();
    test_wall();
    test_tail_chase();
    test_reset_mid_apple();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by 500000, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
